lane_broadcast: RTL and testbench
=================================

// Module: lane_broadcast
// PURPOSE
// - 1-to-n distributor: the opposite direction of the n-lane FP16 reduction trees.
// - Takes one FP16 stream (e.g. a reduce result) and delivers it to the selected lanes/ranks.
// - Broadcast mode: every beat is copied to every selected lane. Scatter mode: beats are
//   dealt to the selected lanes in round-robin order.
// - Sits between the reduction output and the per-rank output ports of the MPI collective datapath.
// PARAMETERS
// - n  4   number of output lanes (1..16)
// - W  16  data width per beat/lane (FP16)
// PORTS
// - aclk           in   1    clock, all logic rising-edge
// - aresetn        in   1    asynchronous, active-low reset
// - outputSelect   in   n    lane mask; bit [n-1-k] enables lane k; sampled on start beat only
// - mode           in   1    0 = broadcast, 1 = scatter; sampled on start beat only
// - idata          in   W    input beat
// - ivalid         in   1    input valid
// - iready         out  1    input ready; depends on register state only (no comb path from oready)
// - istart         in   1    first beat of packet
// - ilast          in   1    last beat of packet (may coincide with istart)
// - odata          out  W*n  lane k at [W*(n-k)-1 -: W] (lane 0 in MSBs)
// - ovalid         out  n    per-lane valid, bit k = lane k
// - oready         in   n    per-lane ready
// - ostart         out  n    per-lane start flag, qualified by ovalid[k]
// - olast          out  n    per-lane last flag, qualified by ovalid[k]
// - drop_err       out  1    1-cycle pulse when an accepted beat is discarded
// BEHAVIOUR
// - Reset (async assert, sync release): all lane FIFOs empty, FSM = IDLE.
//   Resulting outputs: ovalid=0, ostart=0, olast=0, odata=0, drop_err=0; iready=0 while aresetn=0.
// - Handshake: a transfer occurs when valid & ready are both high on a clock edge.
//   Once ovalid[k] rises, it and odata/ostart/olast lane k stay stable until oready[k].
// - Per lane: 2-entry FIFO of {data, start, last}. Push and pop in the same cycle leave the count unchanged.
// - Latency: beat accepted at edge t appears on its lane(s) at t+1 (FIFO registered).
// - Full throughput of 1 beat/cycle when destination lanes are always ready.
// - FSM IDLE
//   - iready=1.
//   - An accepted beat with istart=1 latches outputSelect -> mask and mode -> mode_q,
//     clears the scatter pointer, and is processed as packet beat 0.
//   - Next state: BUSY if ilast=0, else stays IDLE.
//   - An accepted beat with istart=0 is discarded and pulses drop_err.
// - FSM BUSY
//   - mask and mode_q are frozen; outputSelect/mode changes are ignored.
//   - An istart=1 beat is treated as a normal data beat (start flag ignored).
//   - An accepted ilast beat returns the FSM to IDLE.
// - Empty mask on the start beat: the whole packet is accepted and discarded (iready=1);
//   drop_err pulses on the start beat only.
// - Broadcast (mode_q=0)
//   - iready = 1 only if every masked lane FIFO has at least one free slot.
//   - An accepted beat is pushed into all masked lanes with start=istart and last=ilast.
//   - Unmasked lanes are never written.
// - Scatter (mode_q=1)
//   - ptr = index of the current target lane: the lowest set lane at start, advancing to the
//     next set lane in ascending order and wrapping to the lowest.
//   - iready = 1 only if FIFO[ptr] is not full; other lanes do not stall input.
//   - Each scattered word is pushed with start=1 and last=1 (one-word message per delivery).
//   - ptr advances only on an accepted beat.
// - In IDLE, iready is computed with the incoming outputSelect/mode, since they are latched on that beat.
// - Reset mid-packet: FIFOs flush; in-flight beats are lost; FSM returns to IDLE. No drop_err pulse.
// STRUCTURE
// - Shared package mpi_pkg:
//   - FP16_NEG_INF = 16'hFC00
//   - typedef enum logic {BCAST, SCATTER} dist_mode_e
//   - typedef enum logic {IDLE, BUSY} pkt_state_e
//   - function lane_slice(k) for MSB-first lane packing
//   - function next_set_lane(mask, ptr) returning the wrapped next lane
// - Sub-module lane_fifo2 (W+2 bits wide, 2 entries, async active-low reset), instantiated n times via generate.
// - Top level holds the FSM, mask/mode/ptr registers, push-enable decode and iready logic.
// TESTING
// - Reset: aresetn=0 mid-stream -> ovalid=0 and iready=0 next edge; after release iready=1, FIFOs empty.
// - Broadcast: n=4, mask 4'b1011, 3 beats 3C00,4000,4200 with oready=all 1
//   -> lanes 0,2,3 each receive 3C00(ostart),4000,4200(olast) one cycle later; lane 1 ovalid stays 0.
// - Backpressure: broadcast with oready[lane 2]=0
//   -> lane 2 FIFO fills after 2 beats, then iready=0.
//   -> Releasing oready[2] drains lane 2 in order with no duplicated or lost beats on any lane.
// - Scatter: mask 4'b1101, beats A,B,C,D
//   -> A to lane 0, B to lane 1, C to lane 3, D to lane 0 (wrap), each with ostart=olast=1.
// - Errors: beat without istart in IDLE -> drop_err pulse, no lane ovalid.
//   Start beat with mask 0 -> packet swallowed, drop_err once.
// - Single-beat packet (istart=ilast=1): lane shows ostart=olast=1; FSM stays IDLE.
//   A new mask on the next beat takes effect immediately.

Source files
------------

// File: rtl/mpi_pkg.sv
// Shared types and helpers for the MPI collective datapath.
//   FP16_NEG_INF  : FP16 negative infinity (identity for max-reduce)
//   dist_mode_e   : distributor mode, broadcast or scatter
//   pkt_state_e   : packet framing state
//   lane_slice    : LSB position of lane k in an MSB-first packed bus
//   next_set_lane : next enabled lane after ptr, ascending with wrap
package mpi_pkg;

    localparam logic [15:0] FP16_NEG_INF = 16'hFC00;
    localparam int          MAX_LANES    = 16;

    typedef enum logic {BCAST = 1'b0, SCATTER = 1'b1} dist_mode_e;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} pkt_state_e;

    // Lane 0 occupies the most significant slice.
    function automatic int lane_slice(input int k, input int lanes, input int w);
        return w * (lanes - 1 - k);
    endfunction

    // Searches ptr+1, ptr+2, ... modulo lanes. With ptr = lanes-1 this
    // yields the lowest enabled lane. Returns ptr when the mask is empty.
    function automatic logic [3:0] next_set_lane(input logic [15:0] mask,
                                                 input logic [3:0]  ptr,
                                                 input int          lanes);
        logic [3:0] res;
        logic       found;
        int         idx;
        res   = ptr;
        found = 1'b0;
        for (int i = 1; i <= MAX_LANES; i++) begin
            if (i <= lanes && !found) begin
                idx = (int'(ptr) + i) % lanes;
                if (mask[idx[3:0]]) begin
                    res   = idx[3:0];
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/lane_fifo2.sv
// Two-entry per-lane FIFO with registered storage.
//   clk_sys : clock
//   rst_b   : asynchronous active-low reset, clears storage and pointers
//   push    : write wdata (caller guarantees not full)
//   wdata   : entry to write
//   pop     : remove head entry (caller guarantees valid)
//   rdata   : head entry, stable until popped
//   valid   : FIFO not empty
//   full    : both entries occupied
module lane_fifo2 #(
    parameter int DW = 18
) (
    input  logic          clk_sys,
    input  logic          rst_b,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          valid,
    output logic          full
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    assign rdata = mem[rd_ptr];
    assign valid = (count != 2'd0);
    assign full  = (count == 2'd2);

endmodule

// File: rtl/lane_broadcast.sv
// 1-to-n FP16 distributor: broadcast every beat to all selected lanes, or
// deal beats round-robin across the selected lanes (scatter).
//   aclk, aresetn : clock, asynchronous active-low reset
//   outputSelect  : lane mask, bit [n-1-k] enables lane k (start beat only)
//   mode          : 0 broadcast, 1 scatter (start beat only)
//   idata/ivalid/iready/istart/ilast : input stream
//   odata  : lane k at [W*(n-k)-1 -: W]
//   ovalid/oready/ostart/olast       : per-lane output stream, bit k = lane k
//   drop_err : one-cycle pulse after an accepted beat was discarded
//
// state | meaning
// IDLE  | waiting for a start beat; mask/mode taken from the inputs
// BUSY  | inside a packet; mask/mode/ptr frozen in registers
module lane_broadcast
    import mpi_pkg::*;
#(
    parameter int n = 4,
    parameter int W = 16
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic [n-1:0]   outputSelect,
    input  logic           mode,
    input  logic [W-1:0]   idata,
    input  logic           ivalid,
    output logic           iready,
    input  logic           istart,
    input  logic           ilast,
    output logic [W*n-1:0] odata,
    output logic [n-1:0]   ovalid,
    input  logic [n-1:0]   oready,
    output logic [n-1:0]   ostart,
    output logic [n-1:0]   olast,
    output logic           drop_err
);

    localparam int FW = W + 2;

    pkt_state_e    state_q, state_d;
    logic [n-1:0]  mask_q;
    dist_mode_e    mode_q;
    logic [3:0]    ptr_q;
    logic          drop_q;

    logic [n-1:0]  sel_lane;
    logic          idle;
    logic [n-1:0]  eff_mask;
    dist_mode_e    eff_mode;
    logic [3:0]    first_lane;
    logic [3:0]    tgt;
    logic [3:0]    nxt_ptr;
    logic          mask_empty;
    logic          accept;
    logic          pkt_beat;
    logic          drop_now;
    logic [FW-1:0] push_word;

    logic [n-1:0]  push;
    logic [n-1:0]  pop;
    logic [n-1:0]  full;
    logic [n-1:0]  fifo_valid;
    logic [FW-1:0] lane_word [n];

    always_comb begin
        sel_lane = '0;
        for (int k = 0; k < n; k++) begin
            sel_lane[k] = outputSelect[n-1-k];
        end
    end

    assign idle = (state_q == IDLE);

    // In IDLE the start beat's own mask/mode decide readiness and routing.
    always_comb begin
        eff_mask   = idle ? sel_lane : mask_q;
        eff_mode   = idle ? dist_mode_e'(mode) : mode_q;
        first_lane = next_set_lane(16'(eff_mask), 4'(n - 1), n);
        tgt        = idle ? first_lane : ptr_q;
        nxt_ptr    = next_set_lane(16'(eff_mask), tgt, n);
        mask_empty = (eff_mask == '0);
    end

    // Ready depends only on registered FIFO state and the stream inputs.
    always_comb begin
        iready = 1'b0;
        if (!aresetn) begin
            iready = 1'b0;
        end else if (idle && !istart) begin
            iready = 1'b1;
        end else if (mask_empty) begin
            iready = 1'b1;
        end else if (eff_mode == SCATTER) begin
            iready = !full[tgt];
        end else begin
            iready = ((full & eff_mask) == '0);
        end
    end

    assign accept   = ivalid && iready;
    assign pkt_beat = accept && (!idle || istart);
    assign drop_now = accept && idle && (!istart || mask_empty);

    // Scatter deliveries are self-contained one-word messages.
    assign push_word = (eff_mode == SCATTER) ? {idata, 2'b11} : {idata, idle, ilast};

    always_comb begin
        push = '0;
        for (int k = 0; k < n; k++) begin
            if (pkt_beat && !mask_empty) begin
                if (eff_mode == SCATTER) begin
                    push[k] = (tgt == 4'(k));
                end else begin
                    push[k] = eff_mask[k];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (pkt_beat) begin
            state_d = ilast ? IDLE : BUSY;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            mask_q  <= '0;
            mode_q  <= BCAST;
            ptr_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_now;
            if (accept && idle && istart) begin
                mask_q <= sel_lane;
                mode_q <= dist_mode_e'(mode);
            end
            if (pkt_beat) begin
                ptr_q <= nxt_ptr;
            end
        end
    end

    assign drop_err = drop_q;

    for (genvar k = 0; k < n; k++) begin : g_lane
        lane_fifo2 #(.DW(FW)) u_fifo (
            .clk_sys (aclk),
            .rst_b   (aresetn),
            .push    (push[k]),
            .wdata   (push_word),
            .pop     (pop[k]),
            .rdata   (lane_word[k]),
            .valid   (fifo_valid[k]),
            .full    (full[k])
        );

        assign pop[k]    = fifo_valid[k] && oready[k];
        assign ovalid[k] = fifo_valid[k];
        assign ostart[k] = fifo_valid[k] && lane_word[k][1];
        assign olast[k]  = fifo_valid[k] && lane_word[k][0];
        assign odata[lane_slice(k, n, W) +: W] = lane_word[k][FW-1:2];
    end

endmodule

// File: tb/tb_lane_broadcast.sv
module tb_lane_broadcast;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  outputSelect;
    logic        mode;
    logic [15:0] idata;
    logic        ivalid;
    logic        iready;
    logic        istart;
    logic        ilast;
    logic [63:0] odata;
    logic [3:0]  ovalid;
    logic [3:0]  oready;
    logic [3:0]  ostart;
    logic [3:0]  olast;
    logic        drop_err;

    int checks   = 0;
    int failures = 0;

    logic        mon_en = 1'b0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] q2[$];
    logic [15:0] q3[$];

    lane_broadcast #(.n(4), .W(16)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .outputSelect (outputSelect),
        .mode         (mode),
        .idata        (idata),
        .ivalid       (ivalid),
        .iready       (iready),
        .istart       (istart),
        .ilast        (ilast),
        .odata        (odata),
        .ovalid       (ovalid),
        .oready       (oready),
        .ostart       (ostart),
        .olast        (olast),
        .drop_err     (drop_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [15:0] lane_of(input logic [63:0] d, input int k);
        return d[63-16*k -: 16];
    endfunction

    // Records every beat that will be popped at the coming rising edge.
    always @(negedge aclk) begin
        if (mon_en) begin
            if (ovalid[0] && oready[0]) q0.push_back(lane_of(odata, 0));
            if (ovalid[1] && oready[1]) q1.push_back(lane_of(odata, 1));
            if (ovalid[2] && oready[2]) q2.push_back(lane_of(odata, 2));
            if (ovalid[3] && oready[3]) q3.push_back(lane_of(odata, 3));
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Presents one beat and waits (bounded) until it is accepted; returns
    // one time unit after the accepting edge with ivalid deasserted.
    task automatic send_beat(input logic [15:0] d, input logic s, input logic l);
        logic ok;
        ok     = 1'b0;
        ivalid = 1'b1;
        idata  = d;
        istart = s;
        ilast  = l;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (iready === 1'b1) ok = 1'b1;
            @(posedge aclk);
            #1;
        end
        ivalid = 1'b0;
        istart = 1'b0;
        ilast  = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout data=%h iready=%b required=1", d, iready);
        end
    endtask

    task automatic test_reset();
        aresetn      = 1'b0;
        ivalid       = 1'b1;
        istart       = 1'b1;
        ilast        = 1'b0;
        idata        = 16'h1234;
        outputSelect = 4'b1111;
        mode         = 1'b0;
        oready       = 4'hF;
        #2;
        checks++;
        if (iready !== 1'b0) begin failures++; $display("FAIL rst_iready got=%b exp=0", iready); end
        checks++;
        if (ovalid !== 4'b0000 || ostart !== 4'b0000 || olast !== 4'b0000) begin
            failures++; $display("FAIL rst_flags ovalid=%b ostart=%b olast=%b exp=0", ovalid, ostart, olast);
        end
        checks++;
        if (odata !== 64'h0 || drop_err !== 1'b0) begin
            failures++; $display("FAIL rst_data odata=%h drop_err=%b exp=0", odata, drop_err);
        end
        #20;
        aresetn = 1'b1;
        ivalid  = 1'b0;
        tick();
        checks++;
        if (iready !== 1'b1 || ovalid !== 4'b0000) begin
            failures++; $display("FAIL rst_release iready=%b ovalid=%b exp=1/0000", iready, ovalid);
        end
    endtask

    task automatic test_broadcast();
        oready       = 4'hF;
        mode         = 1'b0;
        outputSelect = 4'b1011;
        send_beat(16'h3C00, 1'b1, 1'b0);
        checks++;
        if (ovalid !== 4'b1101 || ostart !== 4'b1101 || olast !== 4'b0000) begin
            failures++; $display("FAIL bc_beat0_flags ovalid=%b ostart=%b olast=%b exp=1101/1101/0000", ovalid, ostart, olast);
        end
        checks++;
        if (lane_of(odata, 0) !== 16'h3C00 || lane_of(odata, 2) !== 16'h3C00 || lane_of(odata, 3) !== 16'h3C00) begin
            failures++; $display("FAIL bc_beat0_data odata=%h exp lanes0,2,3=3C00", odata);
        end
        // Mid-packet selection changes must not affect the frozen mask.
        outputSelect = 4'b0100;
        mode         = 1'b1;
        send_beat(16'h4000, 1'b0, 1'b0);
        checks++;
        if (ovalid !== 4'b1101 || ostart !== 4'b0000 || olast !== 4'b0000) begin
            failures++; $display("FAIL bc_beat1_flags ovalid=%b ostart=%b olast=%b exp=1101/0000/0000", ovalid, ostart, olast);
        end
        checks++;
        if (lane_of(odata, 0) !== 16'h4000 || lane_of(odata, 2) !== 16'h4000 || lane_of(odata, 3) !== 16'h4000) begin
            failures++; $display("FAIL bc_beat1_data odata=%h exp lanes0,2,3=4000", odata);
        end
        send_beat(16'h4200, 1'b0, 1'b1);
        checks++;
        if (ovalid !== 4'b1101 || ostart !== 4'b0000 || olast !== 4'b1101) begin
            failures++; $display("FAIL bc_beat2_flags ovalid=%b ostart=%b olast=%b exp=1101/0000/1101", ovalid, ostart, olast);
        end
        checks++;
        if (lane_of(odata, 0) !== 16'h4200 || lane_of(odata, 2) !== 16'h4200 || lane_of(odata, 3) !== 16'h4200) begin
            failures++; $display("FAIL bc_beat2_data odata=%h exp lanes0,2,3=4200", odata);
        end
        tick();
        checks++;
        if (ovalid !== 4'b0000) begin failures++; $display("FAIL bc_drain ovalid=%b exp=0000", ovalid); end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_q [4];
        exp_q = '{16'h1001, 16'h1002, 16'h1003, 16'h1004};
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        mon_en       = 1'b1;
        oready       = 4'b1011;
        mode         = 1'b0;
        outputSelect = 4'b1011;
        send_beat(16'h1001, 1'b1, 1'b0);
        send_beat(16'h1002, 1'b0, 1'b0);
        ivalid = 1'b1;
        idata  = 16'h1003;
        #1;
        checks++;
        if (iready !== 1'b0) begin failures++; $display("FAIL bp_stall0 iready=%b exp=0", iready); end
        checks++;
        if (ovalid !== 4'b1101 || lane_of(odata, 2) !== 16'h1001) begin
            failures++; $display("FAIL bp_hold0 ovalid=%b lane2=%h exp=1101/1001", ovalid, lane_of(odata, 2));
        end
        tick();
        checks++;
        if (iready !== 1'b0) begin failures++; $display("FAIL bp_stall1 iready=%b exp=0", iready); end
        checks++;
        if (ovalid !== 4'b0100 || lane_of(odata, 2) !== 16'h1001 || ostart !== 4'b0100) begin
            failures++; $display("FAIL bp_hold1 ovalid=%b lane2=%h ostart=%b exp=0100/1001/0100", ovalid, lane_of(odata, 2), ostart);
        end
        tick();
        checks++;
        if (iready !== 1'b0) begin failures++; $display("FAIL bp_stall2 iready=%b exp=0", iready); end
        ivalid = 1'b0;
        oready = 4'hF;
        send_beat(16'h1003, 1'b0, 1'b0);
        send_beat(16'h1004, 1'b0, 1'b1);
        repeat (4) tick();
        mon_en = 1'b0;
        checks++;
        if (q0.size() != 4 || q2.size() != 4 || q3.size() != 4 || q1.size() != 0) begin
            failures++; $display("FAIL bp_counts lane0=%0d lane1=%0d lane2=%0d lane3=%0d exp=4/0/4/4", q0.size(), q1.size(), q2.size(), q3.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q0[i] !== exp_q[i] || q2[i] !== exp_q[i] || q3[i] !== exp_q[i]) begin
                    failures++; $display("FAIL bp_order idx=%0d lane0=%h lane2=%h lane3=%h exp=%h", i, q0[i], q2[i], q3[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_scatter();
        oready       = 4'hF;
        mode         = 1'b1;
        outputSelect = 4'b1101;
        send_beat(16'hA00A, 1'b1, 1'b0);
        checks++;
        if (ovalid !== 4'b0001 || ostart !== 4'b0001 || olast !== 4'b0001 || lane_of(odata, 0) !== 16'hA00A) begin
            failures++; $display("FAIL sc_a ovalid=%b ostart=%b olast=%b lane0=%h exp=0001/0001/0001/A00A", ovalid, ostart, olast, lane_of(odata, 0));
        end
        send_beat(16'hB00B, 1'b0, 1'b0);
        checks++;
        if (ovalid !== 4'b0010 || ostart !== 4'b0010 || olast !== 4'b0010 || lane_of(odata, 1) !== 16'hB00B) begin
            failures++; $display("FAIL sc_b ovalid=%b ostart=%b olast=%b lane1=%h exp=0010/0010/0010/B00B", ovalid, ostart, olast, lane_of(odata, 1));
        end
        send_beat(16'hC00C, 1'b0, 1'b0);
        checks++;
        if (ovalid !== 4'b1000 || ostart !== 4'b1000 || olast !== 4'b1000 || lane_of(odata, 3) !== 16'hC00C) begin
            failures++; $display("FAIL sc_c ovalid=%b ostart=%b olast=%b lane3=%h exp=1000/1000/1000/C00C", ovalid, ostart, olast, lane_of(odata, 3));
        end
        send_beat(16'hD00D, 1'b0, 1'b1);
        checks++;
        if (ovalid !== 4'b0001 || ostart !== 4'b0001 || olast !== 4'b0001 || lane_of(odata, 0) !== 16'hD00D) begin
            failures++; $display("FAIL sc_d_wrap ovalid=%b ostart=%b olast=%b lane0=%h exp=0001/0001/0001/D00D", ovalid, ostart, olast, lane_of(odata, 0));
        end
        tick();
        checks++;
        if (ovalid !== 4'b0000) begin failures++; $display("FAIL sc_drain ovalid=%b exp=0000", ovalid); end
    endtask

    task automatic test_errors();
        oready       = 4'hF;
        mode         = 1'b0;
        outputSelect = 4'b1111;
        send_beat(16'h1111, 1'b0, 1'b0);
        checks++;
        if (drop_err !== 1'b1 || ovalid !== 4'b0000) begin
            failures++; $display("FAIL err_nostart drop_err=%b ovalid=%b exp=1/0000", drop_err, ovalid);
        end
        tick();
        checks++;
        if (drop_err !== 1'b0) begin failures++; $display("FAIL err_pulse_width drop_err=%b exp=0", drop_err); end
        outputSelect = 4'b0000;
        send_beat(16'h2222, 1'b1, 1'b0);
        checks++;
        if (drop_err !== 1'b1 || ovalid !== 4'b0000) begin
            failures++; $display("FAIL err_empty_start drop_err=%b ovalid=%b exp=1/0000", drop_err, ovalid);
        end
        outputSelect = 4'b1111;
        send_beat(16'h2223, 1'b0, 1'b0);
        checks++;
        if (drop_err !== 1'b0 || ovalid !== 4'b0000) begin
            failures++; $display("FAIL err_empty_mid drop_err=%b ovalid=%b exp=0/0000", drop_err, ovalid);
        end
        send_beat(16'h2224, 1'b0, 1'b1);
        checks++;
        if (drop_err !== 1'b0 || ovalid !== 4'b0000) begin
            failures++; $display("FAIL err_empty_last drop_err=%b ovalid=%b exp=0/0000", drop_err, ovalid);
        end
        send_beat(16'h2225, 1'b0, 1'b0);
        checks++;
        if (drop_err !== 1'b1 || ovalid !== 4'b0000) begin
            failures++; $display("FAIL err_back_idle drop_err=%b ovalid=%b exp=1/0000", drop_err, ovalid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        oready       = 4'hF;
        mode         = 1'b0;
        outputSelect = 4'b0100;
        send_beat(16'h5555, 1'b1, 1'b1);
        checks++;
        if (ovalid !== 4'b0010 || ostart !== 4'b0010 || olast !== 4'b0010 || lane_of(odata, 1) !== 16'h5555) begin
            failures++; $display("FAIL single0 ovalid=%b ostart=%b olast=%b lane1=%h exp=0010/0010/0010/5555", ovalid, ostart, olast, lane_of(odata, 1));
        end
        outputSelect = 4'b0001;
        send_beat(16'h6666, 1'b1, 1'b1);
        checks++;
        if (ovalid !== 4'b1000 || ostart !== 4'b1000 || olast !== 4'b1000 || lane_of(odata, 3) !== 16'h6666) begin
            failures++; $display("FAIL single1_newmask ovalid=%b ostart=%b olast=%b lane3=%h exp=1000/1000/1000/6666", ovalid, ostart, olast, lane_of(odata, 3));
        end
        tick();
        checks++;
        if (ovalid !== 4'b0000 || drop_err !== 1'b0) begin
            failures++; $display("FAIL single_drain ovalid=%b drop_err=%b exp=0000/0", ovalid, drop_err);
        end
    endtask

    task automatic test_reset_mid();
        oready       = 4'h0;
        mode         = 1'b0;
        outputSelect = 4'b1111;
        send_beat(16'h7001, 1'b1, 1'b0);
        send_beat(16'h7002, 1'b0, 1'b0);
        checks++;
        if (ovalid !== 4'b1111) begin failures++; $display("FAIL rm_pre ovalid=%b exp=1111", ovalid); end
        ivalid = 1'b1;
        istart = 1'b1;
        idata  = 16'h7003;
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if (ovalid !== 4'b0000 || iready !== 1'b0) begin
            failures++; $display("FAIL rm_async ovalid=%b iready=%b exp=0000/0", ovalid, iready);
        end
        tick();
        checks++;
        if (ovalid !== 4'b0000 || iready !== 1'b0 || drop_err !== 1'b0) begin
            failures++; $display("FAIL rm_hold ovalid=%b iready=%b drop_err=%b exp=0000/0/0", ovalid, iready, drop_err);
        end
        ivalid  = 1'b0;
        aresetn = 1'b1;
        tick();
        checks++;
        if (iready !== 1'b1 || ovalid !== 4'b0000 || drop_err !== 1'b0) begin
            failures++; $display("FAIL rm_release iready=%b ovalid=%b drop_err=%b exp=1/0000/0", iready, ovalid, drop_err);
        end
        oready = 4'hF;
        send_beat(16'h7004, 1'b0, 1'b0);
        checks++;
        if (drop_err !== 1'b1 || ovalid !== 4'b0000) begin
            failures++; $display("FAIL rm_idle drop_err=%b ovalid=%b exp=1/0000", drop_err, ovalid);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_backpressure();
        test_scatter();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
